// File: rtl/comparator_sweeper_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : comparator_sweeper_if
// Purpose  : Bundles the sweeper's control, operand, result and status
//            signals. The master side is the sweeper. The slave side is the
//            environment: the start requester and the comparator under test.
// Revision : 1.0 - initial release
// ============================================================================
interface comparator_sweeper_if #(
  parameter int WIDTH = 3
);
  logic                 i_start;
  logic [WIDTH-1:0]     o_a;
  logic [WIDTH-1:0]     o_b;
  logic [2:0]           i_f;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_pass;
  logic [2*WIDTH:0]     o_err_count;
  logic [WIDTH-1:0]     o_first_err_a;
  logic [WIDTH-1:0]     o_first_err_b;

  modport master (
    input  i_start, i_f,
    output o_a, o_b, o_busy, o_done, o_pass, o_err_count,
           o_first_err_a, o_first_err_b
  );

  modport slave (
    output i_start, i_f,
    input  o_a, o_b, o_busy, o_done, o_pass, o_err_count,
           o_first_err_a, o_first_err_b
  );
endinterface
`default_nettype wire

// File: rtl/comparator_sweeper.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : comparator_sweeper
// Purpose  : Walks every {a,b} operand pair through an external comparator.
//            Each pair is held for SETTLE cycles. The returned code is then
//            checked against the unsigned compare result. Mismatches are
//            counted, and the first failing pair is recorded.
// Revision : 1.0 - initial release
// ============================================================================
module comparator_sweeper #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  comparator_sweeper_if.master  bus
);

  localparam int PW = 2 * WIDTH;      // width of the concatenated {a,b} pair
  localparam int CW = 2 * WIDTH + 1;  // error counter holds up to 2^(2*WIDTH)

  localparam logic [3:0] C_SETTLE = 4'(SETTLE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PW-1:0]    pair_q, pair_d;
  logic [CW-1:0]    err_q, err_d;
  logic [WIDTH-1:0] fea_q, fea_d;
  logic [WIDTH-1:0] feb_q, feb_d;

  logic [WIDTH-1:0] w_cur_a;
  logic [WIDTH-1:0] w_cur_b;
  logic [2:0]       w_exp_f;
  logic             w_mismatch;
  logic             w_last_pair;

  // b occupies the low half, so incrementing the pair carries b into a.
  assign w_cur_a     = pair_q[PW-1:WIDTH];
  assign w_cur_b     = pair_q[WIDTH-1:0];
  assign w_exp_f     = {w_cur_a > w_cur_b, w_cur_a == w_cur_b, w_cur_a < w_cur_b};
  assign w_mismatch  = (bus.i_f != w_exp_f);
  assign w_last_pair = &pair_q;

  // Next-state logic for the sweep sequencer and its result registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pair_d  = pair_q;
    err_d   = err_q;
    fea_d   = fea_q;
    feb_d   = feb_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          state_d = S_WAIT;
          cnt_d   = C_SETTLE;
          pair_d  = '0;
          err_d   = '0;
          fea_d   = '0;
          feb_d   = '0;
        end
      end
      S_WAIT: begin
        // A counter at or below 1 means the settle time has elapsed.
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_mismatch) begin
          err_d = err_q + CW'(1);
          if (err_q == '0) begin
            fea_d = w_cur_a;
            feb_d = w_cur_b;
          end
        end
        if (w_last_pair) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = C_SETTLE;
          pair_d  = pair_q + PW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers. Reset aborts any sweep and discards partial results.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pair_q  <= '0;
      err_q   <= '0;
      fea_q   <= '0;
      feb_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      err_q   <= err_d;
      fea_q   <= fea_d;
      feb_q   <= feb_d;
    end
  end

  assign bus.o_a           = w_cur_a;
  assign bus.o_b           = w_cur_b;
  assign bus.o_busy        = (state_q == S_WAIT) || (state_q == S_CHECK);
  assign bus.o_done        = (state_q == S_DONE);
  assign bus.o_pass        = (state_q == S_DONE) && (err_q == '0);
  assign bus.o_err_count   = err_q;
  assign bus.o_first_err_a = fea_q;
  assign bus.o_first_err_b = feb_q;

endmodule
`default_nettype wire
